// File: rtl/popcount_thermo_expand_if.sv
// Stream bundle for the thermometer expander: count in, 64-bit words out.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; the slave owns in_ready and out_valid.
interface popcount_thermo_expand_if #(
  parameter int CNT_WIDTH = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CNT_WIDTH-1:0] in_count;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_data;
  logic                 out_last;
  logic                 out_sat;

  // Expander side: consumes counts, produces words.
  modport slave (
    input  in_valid,
    input  in_count,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_sat
  );

  // Environment side: produces counts, consumes words.
  modport master (
    output in_valid,
    output in_count,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_sat
  );
endinterface

// File: rtl/popcount_thermo_expand.sv
// Expands a count into WORDS LSB-first thermometer words whose total popcount is min(count, WORDS*64).
// Latency: first word is valid 1 cycle after the count is accepted; then one word per cycle.
// Backpressure: words hold while out_ready is low; a new count is taken only on the last-word handshake or when idle.
module popcount_thermo_expand #(
  parameter int WORDS     = 4,
  parameter int CNT_WIDTH = 9
) (
  input logic                     clk,
  input logic                     rst,
  popcount_thermo_expand_if.slave bus
);

  localparam int                   IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(WORDS * 64);
  localparam logic [CNT_WIDTH-1:0] WORD_BITS = CNT_WIDTH'(64);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 sat_q, sat_d;

  logic                 word_vld;
  logic                 word_last;
  logic                 take_count;
  logic                 take_word;
  logic                 cnt_over;

  // Thermometer of up to 64 set bits, filled from bit 0 upward.
  function automatic logic [63:0] thermo(input logic [CNT_WIDTH-1:0] n);
    logic [63:0] w;
    if (n >= WORD_BITS) begin
      w = '1;
    end else begin
      w = (64'd1 << n[5:0]) - 64'd1;
    end
    return w;
  endfunction

  assign word_vld   = (state_q == EMIT);
  assign word_last  = word_vld && (idx_q == LAST_IDX);
  // Idle, or the last word leaves this cycle: either way the next word slot is free.
  assign bus.in_ready = !word_vld || (bus.out_ready && word_last);
  assign take_count = bus.in_valid && bus.in_ready;
  assign take_word  = word_vld && bus.out_ready;
  assign cnt_over   = (bus.in_count > MAX_CNT);

  // Output word is a pure function of the registered remainder, so it is stable across stalls.
  assign bus.out_valid = word_vld;
  assign bus.out_data  = thermo(rem_q);
  assign bus.out_last  = word_last;
  assign bus.out_sat   = sat_q;

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
    end
  end

  // Next state: a new count wins over word advance (they coincide only on the last word).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    if (take_count) begin
      state_d = EMIT;
      idx_d   = '0;
      rem_d   = cnt_over ? MAX_CNT : bus.in_count;
      sat_d   = cnt_over;
    end else if (take_word) begin
      if (word_last) begin
        state_d = IDLE;
        idx_d   = '0;
        rem_d   = '0;
        sat_d   = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        rem_d = (rem_q >= WORD_BITS) ? (rem_q - WORD_BITS) : '0;
      end
    end
  end

endmodule
